dram_bank_responder: RTL and testbench

DRAM_BANK_RESPONDER -- requirements
Module: dram_bank_responder

---
 rtl/dram_resp_pkg.sv | 15 +
 rtl/dram_resp_dly.sv | 43 ++++
 rtl/dram_bank_responder.sv | 153 +++++++++++++++
 tb/tb_dram_bank_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dram_resp_pkg.sv
// Shared constants for the DRAM bank responder: controller states and legal
// parameter ranges.
package dram_resp_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned DELAY_MIN  = 1;
  localparam int unsigned DELAY_MAX  = 8;
  localparam int unsigned REFLAT_MIN = 1;
  localparam int unsigned REFLAT_MAX = 15;

  localparam int unsigned BUSY_W = $clog2(REFLAT_MAX + 1);

endpackage

// File: rtl/dram_resp_dly.sv
// Read-return pipeline: carries valid plus data through DELAY register stages;
// each stage reloads only when valid arrives, so the final stage holds its data.
module dram_resp_dly #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inVld,
  input  logic [WIDTH-1:0] inData,
  output logic             outVld,
  output logic [WIDTH-1:0] outData
);

  logic             vldPipe  [DELAY];
  logic [WIDTH-1:0] dataPipe [DELAY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vldPipe[0]  <= 1'b0;
      dataPipe[0] <= '0;
    end else begin
      vldPipe[0] <= inVld;
      if (inVld) dataPipe[0] <= inData;
    end
  end

  for (genvar i = 1; i < DELAY; i++) begin : gStage
    always_ff @(posedge clk) begin
      if (!rst) begin
        vldPipe[i]  <= 1'b0;
        dataPipe[i] <= '0;
      end else begin
        vldPipe[i] <= vldPipe[i-1];
        if (vldPipe[i-1]) dataPipe[i] <= dataPipe[i-1];
      end
    end
  end

  assign outVld  = vldPipe[DELAY-1];
  assign outData = dataPipe[DELAY-1];

endmodule

// File: rtl/dram_bank_responder.sv
// Behavioural DRAM bank model: zero-fill sweep after reset, bit-masked writes,
// fixed-latency reads and per-bank refresh busy tracking with error pulses.
module dram_bank_responder
  import dram_resp_pkg::*;
#(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned NUMSROW = 8192,
  parameter int unsigned BITSROW = 13,
  parameter int unsigned DELAY   = 2,
  parameter int unsigned NUMRBNK = 4,
  parameter int unsigned BITRBNK = 2,
  parameter int unsigned REFLAT  = 3,
  parameter int unsigned BITDWSN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               readA,
  input  logic               writeA,
  input  logic [BITSROW-1:0] addrA,
  input  logic [WIDTH-1:0]   dinA,
  input  logic [WIDTH-1:0]   bwA,
  input  logic [BITDWSN-1:0] dwsnA,
  input  logic               refrB,
  input  logic [BITRBNK-1:0] bankB,
  output logic [WIDTH-1:0]   doutA,
  output logic               dout_vld,
  output logic               ready,
  output logic               err_conf,
  output logic               err_refr,
  output logic               err_init
);

  localparam int unsigned DLY = (DELAY < DELAY_MIN) ? DELAY_MIN :
                                (DELAY > DELAY_MAX) ? DELAY_MAX : DELAY;
  localparam int unsigned RLAT = (REFLAT < REFLAT_MIN) ? REFLAT_MIN :
                                 (REFLAT > REFLAT_MAX) ? REFLAT_MAX : REFLAT;
  localparam logic [BITSROW-1:0] LAST_ROW = BITSROW'(NUMSROW - 1);

  logic [0:0]         state, stateNext;
  logic [BITSROW-1:0] sweep, sweepNext;
  logic               errConfNext, errRefrNext, errInitNext;
  logic [BUSY_W-1:0]  busy     [NUMRBNK];
  logic [BUSY_W-1:0]  busyNext [NUMRBNK];

  logic [WIDTH-1:0]   mem [NUMSROW];
  logic [WIDTH-1:0]   memRd;
  logic               memWe;
  logic [BITSROW-1:0] memIdx;
  logic [WIDTH-1:0]   memWdata;

  logic               rdVld;
  logic [WIDTH-1:0]   rdData;
  logic [BITRBNK-1:0] accBank;
  logic               inRange, accBusy;

  logic unusedDwsn;
  assign unusedDwsn = ^dwsnA;

  assign memRd = mem[addrA];

  // Next-state, access arbitration and error detection.
  always_comb begin
    stateNext   = state;
    sweepNext   = sweep;
    errConfNext = 1'b0;
    errRefrNext = 1'b0;
    errInitNext = 1'b0;
    memWe       = 1'b0;
    memIdx      = sweep;
    memWdata    = '0;
    rdVld       = 1'b0;
    rdData      = '0;
    for (int i = 0; i < NUMRBNK; i++) begin
      busyNext[i] = (busy[i] == '0) ? '0 : busy[i] - BUSY_W'(1);
    end
    accBank = addrA[BITRBNK-1:0];
    inRange = 32'(addrA) < NUMSROW;
    accBusy = (busy[accBank] != '0) || (refrB && (bankB == accBank));

    case (state)
      ST_INIT: begin
        memWe       = 1'b1;
        sweepNext   = sweep + BITSROW'(1);
        errInitNext = readA | writeA | refrB;
        if (sweep == LAST_ROW) begin
          stateNext = ST_RUN;
          sweepNext = '0;
        end
      end
      ST_RUN: begin
        // The refresh cycle itself is the first of the RLAT busy cycles.
        if (refrB) begin
          if (busy[bankB] != '0) errRefrNext = 1'b1;
          busyNext[bankB] = BUSY_W'(RLAT - 1);
        end
        if (readA || writeA) begin
          if (readA && writeA) errConfNext = 1'b1;
          if (!inRange)        errConfNext = 1'b1;
          if (accBusy)         errRefrNext = 1'b1;
        end
        // Dropped reads still return, carrying zero data.
        if (readA) begin
          rdVld = 1'b1;
          if (inRange && !accBusy) rdData = memRd;
        end
        if (writeA && !readA && inRange && !accBusy) begin
          memWe    = 1'b1;
          memIdx   = addrA;
          memWdata = (memRd & ~bwA) | (dinA & bwA);
        end
      end
      default: stateNext = ST_INIT;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_INIT;
      sweep    <= '0;
      ready    <= 1'b0;
      err_conf <= 1'b0;
      err_refr <= 1'b0;
      err_init <= 1'b0;
      for (int i = 0; i < NUMRBNK; i++) busy[i] <= '0;
    end else begin
      state    <= stateNext;
      sweep    <= sweepNext;
      ready    <= (state == ST_RUN);
      err_conf <= errConfNext;
      err_refr <= errRefrNext;
      err_init <= errInitNext;
      for (int i = 0; i < NUMRBNK; i++) busy[i] <= busyNext[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst && memWe) mem[memIdx] <= memWdata;
  end

  dram_resp_dly #(
    .WIDTH (WIDTH),
    .DELAY (DLY)
  ) uDly (
    .clk     (clk),
    .rst     (rst),
    .inVld   (rdVld),
    .inData  (rdData),
    .outVld  (dout_vld),
    .outData (doutA)
  );

endmodule

// File: tb/tb_dram_bank_responder.sv
// Directed bench for dram_bank_responder: init sweep, masked writes, refresh
// busy windows, read/write conflict and mid-flight reset.
module tb_dram_bank_responder;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NUMSROW = 16;
  localparam int unsigned BITSROW = 4;
  localparam int unsigned DELAY   = 2;
  localparam int unsigned NUMRBNK = 4;
  localparam int unsigned BITRBNK = 2;
  localparam int unsigned REFLAT  = 3;
  localparam int unsigned BITDWSN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, readA, writeA, refrB;
  logic [BITSROW-1:0] addrA;
  logic [WIDTH-1:0]   dinA, bwA, doutA;
  logic [BITDWSN-1:0] dwsnA;
  logic [BITRBNK-1:0] bankB;
  logic               dout_vld, ready, err_conf, err_refr, err_init;

  int errors = 0;
  int checks = 0;
  int cyc;

  dram_bank_responder #(
    .WIDTH(WIDTH), .NUMSROW(NUMSROW), .BITSROW(BITSROW), .DELAY(DELAY),
    .NUMRBNK(NUMRBNK), .BITRBNK(BITRBNK), .REFLAT(REFLAT), .BITDWSN(BITDWSN)
  ) dut (
    .clk(clk), .rst(rst), .readA(readA), .writeA(writeA), .addrA(addrA),
    .dinA(dinA), .bwA(bwA), .dwsnA(dwsnA), .refrB(refrB), .bankB(bankB),
    .doutA(doutA), .dout_vld(dout_vld), .ready(ready), .err_conf(err_conf),
    .err_refr(err_refr), .err_init(err_init)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    readA = 1'b0; writeA = 1'b0; refrB = 1'b0;
    addrA = '0; dinA = '0; bwA = '0; bankB = '0;
  endtask

  task automatic waitReady(input string tag);
    cyc = 2;
    while (!ready && cyc < 40) begin
      step();
      cyc++;
    end
    chk(tag, 32'(cyc), 32'd17);
  endtask

  initial begin
    rst = 1'b0; dwsnA = 8'hC3;
    idle();
    step(); step(); step();
    chk("rst_dout", doutA, 8'h00);
    chk("rst_vld", dout_vld, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_errs", {err_conf, err_refr, err_init}, 3'b000);

    // Release reset with a read pending: dropped, err_init, sweep continues.
    rst = 1'b1; readA = 1'b1; addrA = 4'd5;
    step();
    chk("init_err", err_init, 1'b1);
    idle();
    step();
    chk("init_err_clr", err_init, 1'b0);
    chk("init_no_vld", dout_vld, 1'b0);
    waitReady("ready_lat");

    // Read zero-filled row 5.
    readA = 1'b1; addrA = 4'd5;
    step(); idle();
    chk("rd5_early", dout_vld, 1'b0);
    step();
    chk("rd5_vld", dout_vld, 1'b1);
    chk("rd5_data", doutA, 8'h00);

    // Masked write pair, read issued right after the second write.
    writeA = 1'b1; addrA = 4'd3; dinA = 8'hFF; bwA = 8'hFF;
    step();
    dinA = 8'h00; bwA = 8'h0F;
    step();
    idle(); readA = 1'b1; addrA = 4'd3;
    step(); idle();
    step();
    chk("rd3_vld", dout_vld, 1'b1);
    chk("rd3_data", doutA, 8'hF0);
    step();
    chk("hold_vld", dout_vld, 1'b0);
    chk("hold_data", doutA, 8'hF0);

    // Refresh bank 1 and probe the busy window through addr 5.
    writeA = 1'b1; addrA = 4'd5; dinA = 8'h5A; bwA = 8'hFF;
    step(); idle();
    step(); step();
    refrB = 1'b1; bankB = 2'd1;
    step(); idle();
    chk("refr_ok", err_refr, 1'b0);
    readA = 1'b1; addrA = 4'd5;
    step(); idle();
    chk("busy_err", err_refr, 1'b1);
    step();
    chk("busy_vld", dout_vld, 1'b1);
    chk("busy_data", doutA, 8'h00);
    chk("busy_err_clr", err_refr, 1'b0);
    readA = 1'b1; addrA = 4'd5;
    step(); idle();
    chk("free_err", err_refr, 1'b0);
    step();
    chk("free_vld", dout_vld, 1'b1);
    chk("free_data", doutA, 8'h5A);

    // Back-to-back refresh of bank 2 reloads its counter.
    refrB = 1'b1; bankB = 2'd2;
    step();
    chk("rr_first", err_refr, 1'b0);
    step(); idle();
    chk("rr_second", err_refr, 1'b1);
    step();
    readA = 1'b1; addrA = 4'd6;
    step(); idle();
    chk("reload_err", err_refr, 1'b1);
    step();
    chk("reload_data", {dout_vld, doutA}, {1'b1, 8'h00});

    // Refresh and access to the same bank in one cycle.
    step(); step();
    refrB = 1'b1; bankB = 2'd3; readA = 1'b1; addrA = 4'd7;
    step(); idle();
    chk("same_err", err_refr, 1'b1);
    step(); step(); step(); step();

    // Read/write conflict on addr 2.
    writeA = 1'b1; addrA = 4'd2; dinA = 8'h33; bwA = 8'hFF;
    step(); idle();
    readA = 1'b1; writeA = 1'b1; addrA = 4'd2; dinA = 8'hAA; bwA = 8'hFF;
    step(); idle();
    chk("conf_err", err_conf, 1'b1);
    step();
    chk("conf_data", {dout_vld, doutA}, {1'b1, 8'h33});
    chk("conf_err_clr", err_conf, 1'b0);
    readA = 1'b1; addrA = 4'd2;
    step(); idle();
    step();
    chk("conf_after", {dout_vld, doutA}, {1'b1, 8'h33});

    // Reset during an in-flight read.
    readA = 1'b1; addrA = 4'd7;
    step();
    idle(); rst = 1'b0;
    step();
    chk("rst_flight_vld", dout_vld, 1'b0);
    step();
    chk("rst_flight_vld2", dout_vld, 1'b0);
    chk("rst_flight_rdy", ready, 1'b0);
    rst = 1'b1;
    step();
    chk("reinit_vld", dout_vld, 1'b0);
    step();
    waitReady("reinit_lat");
    readA = 1'b1; addrA = 4'd3;
    step(); idle();
    step();
    chk("rezero", {dout_vld, doutA}, {1'b1, 8'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
